ntt_stage_sequencer: RTL and testbench
======================================

Name: ntt_stage_sequencer

Overview:
- Sequences the in-place radix-2 NTT butterfly stages over the two half-ring BRAM banks and the PE pair once bit-reversed loading completes.
- Issues one butterfly pair per cycle: shared bank read address, twiddle ROM address and a pipeline-delayed write-back address/enable.
- Inserts a drain gap between stages to remove read-after-write hazards, then reports completion to the output reorder logic.

Parameters:
- RING_DEPTH, 8, log2 of ring size N; banks hold N/2 words each.
- PE_LATENCY, 4, cycles from PE data input to PE ntt output.
- BRAM_LATENCY, 1, cycles from raddr to dout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: bank load complete, begin transform.
- inverse  in  1  transform direction; sampled only on an accepted start.
- rd_addr  out  RING_DEPTH-1  pair index j, shared by both banks.
- rd_en  out  1  rd_addr valid this cycle.
- tw_addr  out  RING_DEPTH+1  twiddle ROM address; MSB = latched inverse.
- wr_addr  out  RING_DEPTH-1  write-back address to both banks.
- wr_en  out  1  write strobe to both banks.
- stage  out  $clog2(RING_DEPTH)  current stage index s.
- last_stage  out  1  high while s == RING_DEPTH-1 (READ or DRAIN).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, delay line cleared, latched inverse 0. Reset mid-transform aborts immediately, and no wr_en fires afterwards.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start -> READ.
  - On that edge: s=0, j=0, busy=1, latch inverse.
- READ:
  - rd_en=1 and rd_addr=j every cycle.
  - j increments; at j == N/2-1, go to DRAIN and set j=0.
- DRAIN:
  - Exactly L = BRAM_LATENCY+PE_LATENCY cycles with rd_en=0.
  - On the last DRAIN cycle: if s < RING_DEPTH-1, then s++ and go to READ; otherwise go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - stage returns to 0.
- tw_addr, registered alongside rd_addr:
  - Low RING_DEPTH bits = 2^s + (j >> (RING_DEPTH-1-s)).
  - Bit RING_DEPTH = latched inverse.
  - 0 when rd_en=0.
- Write-back:
  - wr_en and wr_addr are rd_en and rd_addr delayed by exactly L cycles through a shift register.
  - The last write of a stage lands on the final DRAIN cycle.
  - The first read of the next stage is the following cycle; there is never a same-address read/write overlap across stages.
- start while busy, or in the DONE cycle: ignored, with no restart and no inverse update.
- start and reset in the same cycle: reset wins.
- Total latency from start cycle to done pulse: RING_DEPTH*(N/2 + L) + 1 cycles.
- Every pair j in 0..N/2-1 is read exactly once per stage, in ascending order, and written once per stage.

Test Plan:
1. RING_DEPTH=3, PE_LATENCY=2, BRAM_LATENCY=1; start pulse at cycle 0, inverse=0 -> rd_en high cycles 1-4 with rd_addr 0,1,2,3, tw_addr 1,1,1,1; wr_en high cycles 4-7 with wr_addr 0,1,2,3; stage 1 reads begin cycle 8.
2. Same config, full run -> tw_addr per stage: s1: 2,2,3,3; s2: 4,5,6,7; last_stage high cycles 15-21; done single pulse at cycle 22; busy high cycles 1-21; 12 total wr_en cycles.
3. inverse=1 at start, toggled to 0 mid-run -> tw_addr bit 3 stays 1 for all rd_en cycles; s0 tw_addr = 9.
4. start re-pulsed at cycles 5 and 22 (DONE cycle) -> no effect; done pulses once; next start at cycle 24 reruns identically.
5. reset asserted at cycle 6 (stage 0 DRAIN) -> cycle 7 onward: all outputs 0, no wr_en ever; a start at cycle 10 produces the sequence of test 1 offset by 10.
6. Defaults (RING_DEPTH=8, PE_LATENCY=4) -> done exactly 1065 cycles after start; each stage has 128 consecutive rd_en cycles separated by 5 idle cycles.

Source files
------------

// File: rtl/ntt_stage_sequencer_if.sv
// Handshake and memory-control bundle between the NTT stage sequencer and
// the surrounding bank/PE/twiddle logic.
interface ntt_stage_sequencer_if #(
    parameter int RING_DEPTH = 8
);
    logic                          start;
    logic                          inverse;
    logic [RING_DEPTH-2:0]         rd_addr;
    logic                          rd_en;
    logic [RING_DEPTH:0]           tw_addr;
    logic [RING_DEPTH-2:0]         wr_addr;
    logic                          wr_en;
    logic [$clog2(RING_DEPTH)-1:0] stage;
    logic                          last_stage;
    logic                          busy;
    logic                          done;

    // Controller side: launches a transform and observes progress.
    modport master (
        output start, inverse,
        input  rd_addr, rd_en, tw_addr, wr_addr, wr_en,
        input  stage, last_stage, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, inverse,
        output rd_addr, rd_en, tw_addr, wr_addr, wr_en,
        output stage, last_stage, busy, done
    );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Walks the radix-2 NTT butterfly stages over the two half-ring banks:
// one pair read per cycle, twiddle address alongside, write-back delayed by
// the bank+PE latency, and a drain gap between stages so a stage never reads
// a word the previous stage has not yet written.
module ntt_stage_sequencer #(
    parameter int RING_DEPTH   = 8,
    parameter int PE_LATENCY   = 4,
    parameter int BRAM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    ntt_stage_sequencer_if.slave bus
);
    localparam int N_HALF = 1 << (RING_DEPTH - 1);
    localparam int AW     = RING_DEPTH - 1;
    localparam int TW     = RING_DEPTH + 1;
    localparam int SW     = $clog2(RING_DEPTH);
    localparam int L      = BRAM_LATENCY + PE_LATENCY;
    localparam int CW     = $clog2(L + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   j, j_nxt;
    logic [SW-1:0]   s, s_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            inv, inv_nxt;
    logic [TW-1:0]   tw_q;
    logic            rd_en_c;
    logic [L-1:0]    wb_vld;
    logic [AW-1:0]   wb_addr [L];

    // Twiddle index for stage st, pair jj: the stage's twiddle block starts
    // at 2^st and holds 2^st distinct factors, selected by the top st bits of
    // the pair index. The direction bit picks the forward or inverse table.
    function automatic logic [TW-1:0] tw_index(
        input logic [SW-1:0] st,
        input logic [AW-1:0] jj,
        input logic          iv
    );
        logic [RING_DEPTH-1:0] base;
        logic [RING_DEPTH-1:0] off;
        base = RING_DEPTH'(1) << st;
        off  = {1'b0, jj} >> (AW - int'(st));
        return {iv, base + off};
    endfunction

    // Next-state and counter update for the stage walk.
    always_comb begin
        state_nxt = state;
        j_nxt     = j;
        s_nxt     = s;
        cnt_nxt   = cnt;
        inv_nxt   = inv;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = READ;
                    j_nxt     = '0;
                    s_nxt     = '0;
                    cnt_nxt   = '0;
                    inv_nxt   = bus.inverse;
                end
            end
            READ: begin
                if (j == AW'(N_HALF - 1)) begin
                    state_nxt = DRAIN;
                    j_nxt     = '0;
                    cnt_nxt   = '0;
                end else begin
                    j_nxt = j + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CW'(L - 1)) begin
                    cnt_nxt = '0;
                    if (s != SW'(RING_DEPTH - 1)) begin
                        s_nxt     = s + 1'b1;
                        state_nxt = READ;
                    end else begin
                        s_nxt     = '0;
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM, pair index, stage and latched direction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            j     <= '0;
            s     <= '0;
            cnt   <= '0;
            inv   <= 1'b0;
        end else begin
            state <= state_nxt;
            j     <= j_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
            inv   <= inv_nxt;
        end
    end

    // Twiddle address registered from the same next values that drive the
    // read address, so both present together in each READ cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tw_q <= '0;
        end else if (state_nxt == READ) begin
            tw_q <= tw_index(s_nxt, j_nxt, inv_nxt);
        end else begin
            tw_q <= '0;
        end
    end

    assign rd_en_c = (state == READ);

    // Write-back delay line: each read re-emerges L cycles later as the
    // matching write, landing the stage's last write on the final drain cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_vld <= '0;
            for (int i = 0; i < L; i++) begin
                wb_addr[i] <= '0;
            end
        end else begin
            wb_vld[0]  <= rd_en_c;
            wb_addr[0] <= j;
            for (int i = 1; i < L; i++) begin
                wb_vld[i]  <= wb_vld[i-1];
                wb_addr[i] <= wb_addr[i-1];
            end
        end
    end

    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = j;
    assign bus.tw_addr    = tw_q;
    assign bus.wr_en      = wb_vld[L-1];
    assign bus.wr_addr    = wb_addr[L-1];
    assign bus.stage      = s;
    assign bus.last_stage = ((state == READ) || (state == DRAIN)) &&
                            (s == SW'(RING_DEPTH - 1));
    assign bus.busy       = (state == READ) || (state == DRAIN);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench: a small instance (N=8, L=3) checked cycle by cycle against
// hand-derived tables, and a default instance (N=256, L=5) checked on
// overall timing.
module tb_ntt_stage_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt_stage_sequencer_if #(.RING_DEPTH(3)) sbus ();
    ntt_stage_sequencer_if #(.RING_DEPTH(8)) lbus ();

    ntt_stage_sequencer #(.RING_DEPTH(3), .PE_LATENCY(2), .BRAM_LATENCY(1)) dut_s (
        .clk(clk), .reset(reset), .bus(sbus)
    );
    ntt_stage_sequencer dut_l (
        .clk(clk), .reset(reset), .bus(lbus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected per-cycle outputs for one full small run, start at cycle 0.
    bit exp_rd_en[24]   = '{0,1,1,1,1,0,0,0,1,1,1,1,0,0,0,1,1,1,1,0,0,0,0,0};
    int exp_rd_addr[24] = '{0,0,1,2,3,0,0,0,0,1,2,3,0,0,0,0,1,2,3,0,0,0,0,0};
    int exp_tw[24]      = '{0,1,1,1,1,0,0,0,2,2,3,3,0,0,0,4,5,6,7,0,0,0,0,0};
    bit exp_wr_en[24]   = '{0,0,0,0,1,1,1,1,0,0,0,1,1,1,1,0,0,0,1,1,1,1,0,0};
    int exp_wr_addr[24] = '{0,0,0,0,0,1,2,3,0,0,0,0,1,2,3,0,0,0,0,1,2,3,0,0};
    int exp_stage[24]   = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,2,2,2,2,2,2,2,0,0};
    bit exp_last[24]    = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,0,0};
    bit exp_busy[24]    = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
    bit exp_done[24]    = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};

    bit cap_rd_en[64];
    int cap_rd_addr[64];
    int cap_tw[64];
    bit cap_wr_en[64];
    int cap_wr_addr[64];
    int cap_stage[64];
    bit cap_last[64];
    bit cap_busy[64];
    bit cap_done[64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles on the small DUT with start asserted in cycle 0 and
    // optionally in cycles st_a/st_b, inverse flipped at inv_flip, and reset
    // asserted in cycle rst_c; records outputs per cycle.
    task automatic capture(input int n, input bit inv0, input int inv_flip,
                           input int st_a, input int st_b, input int rst_c);
        for (int c = 0; c < n; c++) begin
            sbus.start = (c == 0) || (c == st_a) || (c == st_b);
            if (c == 0) sbus.inverse = inv0;
            else if (c == inv_flip) sbus.inverse = ~inv0;
            reset = (c == rst_c);
            cap_rd_en[c]   = sbus.rd_en;
            cap_rd_addr[c] = int'(sbus.rd_addr);
            cap_tw[c]      = int'(sbus.tw_addr);
            cap_wr_en[c]   = sbus.wr_en;
            cap_wr_addr[c] = int'(sbus.wr_addr);
            cap_stage[c]   = int'(sbus.stage);
            cap_last[c]    = sbus.last_stage;
            cap_busy[c]    = sbus.busy;
            cap_done[c]    = sbus.done;
            tick();
        end
        sbus.start   = 1'b0;
        sbus.inverse = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({sbus.rd_en, sbus.rd_addr, sbus.tw_addr, sbus.wr_en, sbus.wr_addr,
             sbus.stage, sbus.last_stage, sbus.busy, sbus.done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_small got=%b exp=0", {sbus.rd_en, sbus.rd_addr, sbus.tw_addr,
                     sbus.wr_en, sbus.wr_addr, sbus.stage, sbus.last_stage, sbus.busy, sbus.done});
        end
        tests_run++;
        if ({lbus.rd_en, lbus.rd_addr, lbus.tw_addr, lbus.wr_en, lbus.wr_addr,
             lbus.stage, lbus.last_stage, lbus.busy, lbus.done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_default got=%b exp=0", {lbus.rd_en, lbus.rd_addr, lbus.tw_addr,
                     lbus.wr_en, lbus.wr_addr, lbus.stage, lbus.last_stage, lbus.busy, lbus.done});
        end
    endtask

    task automatic test_first_stage();
        capture(24, 1'b0, -1, -1, -1, -1);
        for (int c = 0; c < 12; c++) begin
            tests_run++;
            if (cap_rd_en[c] !== exp_rd_en[c] || cap_rd_addr[c] !== exp_rd_addr[c] ||
                cap_tw[c] !== exp_tw[c]) begin
                tests_failed++;
                $display("FAIL s0_read cyc=%0d got en=%0d addr=%0d tw=%0d exp en=%0d addr=%0d tw=%0d",
                         c, cap_rd_en[c], cap_rd_addr[c], cap_tw[c],
                         exp_rd_en[c], exp_rd_addr[c], exp_tw[c]);
            end
            tests_run++;
            if (cap_wr_en[c] !== exp_wr_en[c] || cap_wr_addr[c] !== exp_wr_addr[c]) begin
                tests_failed++;
                $display("FAIL s0_write cyc=%0d got en=%0d addr=%0d exp en=%0d addr=%0d",
                         c, cap_wr_en[c], cap_wr_addr[c], exp_wr_en[c], exp_wr_addr[c]);
            end
        end
    endtask

    task automatic test_full_run();
        int wr_cnt;
        int done_cnt;
        wr_cnt   = 0;
        done_cnt = 0;
        capture(24, 1'b0, -1, -1, -1, -1);
        for (int c = 0; c < 24; c++) begin
            wr_cnt   += int'(cap_wr_en[c]);
            done_cnt += int'(cap_done[c]);
            tests_run++;
            if (cap_rd_en[c] !== exp_rd_en[c] || cap_rd_addr[c] !== exp_rd_addr[c] ||
                cap_tw[c] !== exp_tw[c] || cap_wr_en[c] !== exp_wr_en[c] ||
                cap_wr_addr[c] !== exp_wr_addr[c]) begin
                tests_failed++;
                $display("FAIL full_mem cyc=%0d got rd=%0d/%0d tw=%0d wr=%0d/%0d exp rd=%0d/%0d tw=%0d wr=%0d/%0d",
                         c, cap_rd_en[c], cap_rd_addr[c], cap_tw[c], cap_wr_en[c], cap_wr_addr[c],
                         exp_rd_en[c], exp_rd_addr[c], exp_tw[c], exp_wr_en[c], exp_wr_addr[c]);
            end
            tests_run++;
            if (cap_stage[c] !== exp_stage[c] || cap_last[c] !== exp_last[c] ||
                cap_busy[c] !== exp_busy[c] || cap_done[c] !== exp_done[c]) begin
                tests_failed++;
                $display("FAIL full_ctrl cyc=%0d got stage=%0d last=%0d busy=%0d done=%0d exp stage=%0d last=%0d busy=%0d done=%0d",
                         c, cap_stage[c], cap_last[c], cap_busy[c], cap_done[c],
                         exp_stage[c], exp_last[c], exp_busy[c], exp_done[c]);
            end
        end
        tests_run++;
        if (wr_cnt !== 12) begin
            tests_failed++;
            $display("FAIL full_wr_count got=%0d exp=12", wr_cnt);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL full_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_inverse();
        capture(24, 1'b1, 3, -1, -1, -1);
        for (int c = 0; c < 24; c++) begin
            tests_run++;
            if (cap_tw[c] !== (exp_rd_en[c] ? (exp_tw[c] + 8) : 0) || cap_rd_en[c] !== exp_rd_en[c]) begin
                tests_failed++;
                $display("FAIL inverse_tw cyc=%0d got tw=%0d en=%0d exp tw=%0d en=%0d", c, cap_tw[c],
                         cap_rd_en[c], exp_rd_en[c] ? (exp_tw[c] + 8) : 0, exp_rd_en[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int run = 0; run < 2; run++) begin
            if (run == 0) capture(24, 1'b0, -1, 5, 22, -1);
            else          capture(24, 1'b0, -1, -1, -1, -1);
            for (int c = 0; c < 24; c++) begin
                tests_run++;
                if (cap_rd_en[c] !== exp_rd_en[c] || cap_tw[c] !== exp_tw[c] ||
                    cap_wr_en[c] !== exp_wr_en[c] || cap_busy[c] !== exp_busy[c] ||
                    cap_done[c] !== exp_done[c]) begin
                    tests_failed++;
                    $display("FAIL b2b run=%0d cyc=%0d got rd=%0d tw=%0d wr=%0d busy=%0d done=%0d exp rd=%0d tw=%0d wr=%0d busy=%0d done=%0d",
                             run, c, cap_rd_en[c], cap_tw[c], cap_wr_en[c], cap_busy[c], cap_done[c],
                             exp_rd_en[c], exp_tw[c], exp_wr_en[c], exp_busy[c], exp_done[c]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        capture(10, 1'b0, -1, -1, -1, 6);
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (c <= 6) begin
                if (cap_rd_en[c] !== exp_rd_en[c] || cap_wr_en[c] !== exp_wr_en[c] ||
                    cap_busy[c] !== exp_busy[c]) begin
                    tests_failed++;
                    $display("FAIL abort_pre cyc=%0d got rd=%0d wr=%0d busy=%0d exp rd=%0d wr=%0d busy=%0d",
                             c, cap_rd_en[c], cap_wr_en[c], cap_busy[c],
                             exp_rd_en[c], exp_wr_en[c], exp_busy[c]);
                end
            end else begin
                if ({cap_rd_en[c], cap_wr_en[c], cap_last[c], cap_busy[c], cap_done[c]} !== 5'b0 ||
                    cap_rd_addr[c] !== 0 || cap_tw[c] !== 0 || cap_wr_addr[c] !== 0 ||
                    cap_stage[c] !== 0) begin
                    tests_failed++;
                    $display("FAIL abort_post cyc=%0d got rd=%0d wr=%0d busy=%0d tw=%0d stage=%0d exp all 0",
                             c, cap_rd_en[c], cap_wr_en[c], cap_busy[c], cap_tw[c], cap_stage[c]);
                end
            end
        end
        capture(24, 1'b0, -1, -1, -1, -1);
        for (int c = 0; c < 24; c++) begin
            tests_run++;
            if (cap_rd_en[c] !== exp_rd_en[c] || cap_rd_addr[c] !== exp_rd_addr[c] ||
                cap_tw[c] !== exp_tw[c] || cap_wr_en[c] !== exp_wr_en[c] ||
                cap_wr_addr[c] !== exp_wr_addr[c] || cap_done[c] !== exp_done[c]) begin
                tests_failed++;
                $display("FAIL abort_rerun cyc=%0d got rd=%0d/%0d tw=%0d wr=%0d/%0d done=%0d exp rd=%0d/%0d tw=%0d wr=%0d/%0d done=%0d",
                         c, cap_rd_en[c], cap_rd_addr[c], cap_tw[c], cap_wr_en[c], cap_wr_addr[c], cap_done[c],
                         exp_rd_en[c], exp_rd_addr[c], exp_tw[c], exp_wr_en[c], exp_wr_addr[c], exp_done[c]);
            end
        end
    endtask

    task automatic test_start_reset_collision();
        sbus.start = 1'b1;
        reset      = 1'b1;
        tick();
        sbus.start = 1'b0;
        reset      = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (sbus.busy !== 1'b0 || sbus.rd_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL collision cyc=%0d got busy=%0d rd_en=%0d exp 0 0", c, sbus.busy, sbus.rd_en);
            end
            tick();
        end
    endtask

    task automatic test_defaults();
        int  done_cyc, done_cnt, wr_cnt, runs, run_len, gap_len, bad_len, bad_gap;
        bit  prev;
        done_cyc = -1; done_cnt = 0; wr_cnt = 0; runs = 0;
        run_len = 0; gap_len = 0; bad_len = 0; bad_gap = 0; prev = 1'b0;
        lbus.inverse = 1'b0;
        lbus.start   = 1'b1;
        tick();
        lbus.start   = 1'b0;
        for (int c = 1; c <= 1200; c++) begin
            if (lbus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            wr_cnt += int'(lbus.wr_en);
            if (lbus.rd_en) begin
                if (!prev) begin
                    if (runs > 0 && gap_len != 5) bad_gap++;
                    runs++;
                    run_len = 0;
                end
                run_len++;
                gap_len = 0;
            end else begin
                if (prev && run_len != 128) bad_len++;
                gap_len++;
            end
            prev = lbus.rd_en;
            tick();
        end
        tests_run++;
        if (done_cyc !== 1065) begin
            tests_failed++;
            $display("FAIL dflt_latency got=%0d exp=1065", done_cyc);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL dflt_done_count got=%0d exp=1", done_cnt);
        end
        tests_run++;
        if (runs !== 8 || bad_len !== 0 || bad_gap !== 0) begin
            tests_failed++;
            $display("FAIL dflt_runs got runs=%0d bad_len=%0d bad_gap=%0d exp 8 0 0", runs, bad_len, bad_gap);
        end
        tests_run++;
        if (wr_cnt !== 1024) begin
            tests_failed++;
            $display("FAIL dflt_wr_count got=%0d exp=1024", wr_cnt);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sbus.start   = 1'b0;
        sbus.inverse = 1'b0;
        lbus.start   = 1'b0;
        lbus.inverse = 1'b0;
        @(negedge clk);
        tick();
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_first_stage();
        test_full_run();
        test_inverse();
        test_back_to_back();
        test_reset_abort();
        test_start_reset_collision();
        test_defaults();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
